wf_outstanding_tracker: RTL and testbench
=========================================

Name: wf_outstanding_tracker

Overview:
Per-wavefront outstanding-instruction scoreboard between issue and the ALU/LSU retire paths. Issue increments a per-wavefront counter and retire decrements it. Flush clears it, and flush dominates both issue and retire. The block publishes a registered busy mask that issue uses to gate barrier, halt and end-of-wavefront, plus sticky error flags for the verification and debug buses.

Parameters:
NUM_WF, 40, number of wavefront slots tracked
WFID_W, 6, wavefront id width; must satisfy 2^WFID_W >= NUM_WF
CNT_W, 4, per-wavefront counter width; saturates at 2^CNT_W-1

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
issue_valid  input  1  one instruction issued for issue_wfid
issue_wfid  input  WFID_W  wavefront id of the issued instruction
retire_valid  input  1  one instruction retired for retire_wfid
retire_wfid  input  WFID_W  wavefront id of the retired instruction
flush_valid  input  1  discard all outstanding work for flush_wfid
flush_wfid  input  WFID_W  wavefront id to flush
query_wfid  input  WFID_W  wavefront id for count readout
query_count  output  CNT_W  registered counter of query_wfid
busy_mask  output  NUM_WF  registered; bit i = (counter[i] != 0)
overflow_err  output  1  sticky; issue seen at saturated count
underflow_err  output  1  sticky; retire seen at zero count
range_err  output  1  sticky; any valid with wfid >= NUM_WF
issue_stall  output  1  present only with WF_TRACKER_DRAIN_EN; otherwise absent

Behaviour:
- Reset (rst low, async): all counters, busy_mask, query_count and the three error flags go to 0. Drain FSM (if present) goes to IDLE and issue_stall to 0.
- Per wavefront i, each cycle:
  - inc = issue_valid & issue_wfid==i
  - dec = retire_valid & retire_wfid==i
  - fl = flush_valid & flush_wfid==i
- Priority for counter[i] next value:
  - fl: 0, regardless of inc/dec.
  - inc & dec: unchanged (net zero, no error even at 0 or max).
  - inc only: +1. If already at max, hold and set overflow_err.
  - dec only: −1. If already 0, hold and set underflow_err.
  - none: hold.
- Retire for a wavefront flushed the same cycle: dropped silently, no underflow_err.
- Issue for a wavefront flushed the same cycle: dropped.
- Out-of-range wfid (>= NUM_WF) on any valid: no counter changes; set range_err.
- busy_mask is computed from the next counter value and registered, so it reflects an event 1 cycle after the event edge.
  - Example: issue at edge N gives busy bit = 1 after edge N.
- query_count = counter[query_wfid] registered one cycle after query_wfid is applied; reflects counter state before that same edge's update. query_wfid out of range returns 0.
- Error flags clear only on reset.
- Reset asserted mid-operation: immediate clear, and no partial updates survive.

Optional Feature:
Macro WF_TRACKER_DRAIN_EN. With it, adds ports:
- drain_req input 1: level request.
- drain_ack output 1: registered.
- issue_stall output 1: registered.

The drain FSM has three states:
- IDLE: drain_ack = 0, issue_stall = 0. drain_req = 1 moves to DRAINING.
- DRAINING: issue_stall = 1. issue_valid arriving while issue_stall = 1 is still counted and also sets overflow_err as a protocol violation. When busy_mask == 0, move to DONE.
- DONE: drain_ack = 1, issue_stall = 1, held while drain_req stays 1. drain_req = 0 returns to IDLE; ack and stall drop on that next edge.
- Flush is allowed in any state.
- drain_req dropped during DRAINING returns to IDLE.

Without the macro, these ports and the FSM do not exist and issue is never stalled.

Test Plan:
- Reset, then 3 issues to wfid 5 on consecutive cycles → query_count(5)=3, busy_mask[5]=1 one cycle after first issue; other bits 0.
- Counter of wfid 7 at 2; issue and retire both to 7 in the same cycle → count stays 2, no error flags.
- Counter of wfid 0 at 0; retire to 0 → count 0, underflow_err=1 and stays 1 until rst low.
- 16 issues to wfid 39 with CNT_W=4 → count 15, overflow_err=1 after the 16th; one retire → 14.
- Counter of wfid 12 at 4; flush 12 and retire 12 in the same cycle → count 0, busy_mask[12]=0 next cycle, underflow_err stays 0. Issue with wfid 45 → range_err=1, no counter change.
- With WF_TRACKER_DRAIN_EN, wfid 3 at count 2:
  - raise drain_req → issue_stall=1 next cycle.
  - two retires → drain_ack=1 one cycle after busy_mask==0.
  - drop drain_req → ack and stall drop next cycle.

Source files
------------

// File: rtl/wf_outstanding_tracker.sv
// Per-wavefront outstanding-instruction scoreboard with registered busy mask and sticky error flags.
// Optional drain handshake (drain_req/drain_ack/issue_stall) is enabled by defining WF_TRACKER_DRAIN_EN.
module wf_outstanding_tracker #(
  parameter int NUM_WF = 40,
  parameter int WFID_W = 6,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [WFID_W-1:0] issue_wfid,
  input  logic              retire_valid,
  input  logic [WFID_W-1:0] retire_wfid,
  input  logic              flush_valid,
  input  logic [WFID_W-1:0] flush_wfid,
  input  logic [WFID_W-1:0] query_wfid,
  output logic [CNT_W-1:0]  query_count,
  output logic [NUM_WF-1:0] busy_mask,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              range_err
`ifdef WF_TRACKER_DRAIN_EN
  ,
  input  logic              drain_req,
  output logic              drain_ack,
  output logic              issue_stall
`endif
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [WFID_W:0]   NUM_WF_L = (WFID_W + 1)'(NUM_WF);

  logic [CNT_W-1:0]  cnt      [NUM_WF];
  logic [CNT_W-1:0]  cnt_next [NUM_WF];
  logic [NUM_WF-1:0] inc_vec;
  logic [NUM_WF-1:0] dec_vec;
  logic [NUM_WF-1:0] fl_vec;
  logic [NUM_WF-1:0] busy_next;
  logic              ovf_hit;
  logic              unf_hit;
  logic              range_hit;
  logic              stall_viol;
  logic              query_in_range;

  // Flush wins outright; a simultaneous issue+retire nets to zero without raising errors.
  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    fl_vec    = '0;
    busy_next = '0;
    ovf_hit   = 1'b0;
    unf_hit   = 1'b0;
    for (int i = 0; i < NUM_WF; i++) begin
      inc_vec[i]  = issue_valid  && (issue_wfid  == WFID_W'(i));
      dec_vec[i]  = retire_valid && (retire_wfid == WFID_W'(i));
      fl_vec[i]   = flush_valid  && (flush_wfid  == WFID_W'(i));
      cnt_next[i] = cnt[i];
      if (fl_vec[i]) begin
        cnt_next[i] = '0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        if (cnt[i] == CNT_MAX) ovf_hit = 1'b1;
        else                   cnt_next[i] = cnt[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt[i] == '0) unf_hit = 1'b1;
        else              cnt_next[i] = cnt[i] - 1'b1;
      end
      busy_next[i] = |cnt_next[i];
    end
  end

  assign range_hit = (issue_valid  && ({1'b0, issue_wfid}  >= NUM_WF_L)) ||
                     (retire_valid && ({1'b0, retire_wfid} >= NUM_WF_L)) ||
                     (flush_valid  && ({1'b0, flush_wfid}  >= NUM_WF_L));

  assign query_in_range = {1'b0, query_wfid} < NUM_WF_L;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WF; i++) cnt[i] <= '0;
      busy_mask     <= '0;
      query_count   <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      range_err     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WF; i++) cnt[i] <= cnt_next[i];
      busy_mask     <= busy_next;
      query_count   <= query_in_range ? cnt[query_wfid] : '0;
      overflow_err  <= overflow_err | ovf_hit | stall_viol;
      underflow_err <= underflow_err | unf_hit;
      range_err     <= range_err | range_hit;
    end
  end

`ifdef WF_TRACKER_DRAIN_EN
  typedef enum logic [1:0] {IDLE, DRAINING, DONE} drain_state_t;

  drain_state_t state;
  drain_state_t state_next;
  logic         stall_next;
  logic         ack_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      issue_stall <= 1'b0;
      drain_ack   <= 1'b0;
    end else begin
      state       <= state_next;
      issue_stall <= stall_next;
      drain_ack   <= ack_next;
    end
  end

  // Drain completes on the registered busy mask, so ack trails the last retire by one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (drain_req) state_next = DRAINING;
      DRAINING: begin
        if (!drain_req)          state_next = IDLE;
        else if (busy_mask == '0) state_next = DONE;
      end
      DONE:     if (!drain_req) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    stall_next = (state_next != IDLE);
    ack_next   = (state_next == DONE);
  end

  assign stall_viol = issue_valid && issue_stall;
`else
  assign stall_viol = 1'b0;
`endif

endmodule

// File: tb/tb_wf_outstanding_tracker.sv
// Directed scoreboard bench for wf_outstanding_tracker; drain checks run when WF_TRACKER_DRAIN_EN is defined.
module tb_wf_outstanding_tracker;

  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              issue_valid = 1'b0;
  logic [WFID_W-1:0] issue_wfid = '0;
  logic              retire_valid = 1'b0;
  logic [WFID_W-1:0] retire_wfid = '0;
  logic              flush_valid = 1'b0;
  logic [WFID_W-1:0] flush_wfid = '0;
  logic [WFID_W-1:0] query_wfid = '0;
  logic [CNT_W-1:0]  query_count;
  logic [NUM_WF-1:0] busy_mask;
  logic              overflow_err;
  logic              underflow_err;
  logic              range_err;
`ifdef WF_TRACKER_DRAIN_EN
  logic              drain_req = 1'b0;
  logic              drain_ack;
  logic              issue_stall;
`endif

  wf_outstanding_tracker #(.NUM_WF(NUM_WF), .WFID_W(WFID_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_wfid    (issue_wfid),
    .retire_valid  (retire_valid),
    .retire_wfid   (retire_wfid),
    .flush_valid   (flush_valid),
    .flush_wfid    (flush_wfid),
    .query_wfid    (query_wfid),
    .query_count   (query_count),
    .busy_mask     (busy_mask),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err),
    .range_err     (range_err)
`ifdef WF_TRACKER_DRAIN_EN
    ,
    .drain_req     (drain_req),
    .drain_ack     (drain_ack),
    .issue_stall   (issue_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] value;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  logic [NUM_WF-1:0] busy_exp = '0;

  function automatic logic [63:0] observe(int sel);
    case (sel)
      0: return 64'(query_count);
      1: return 64'(busy_mask);
      2: return 64'(overflow_err);
      3: return 64'(underflow_err);
      4: return 64'(range_err);
`ifdef WF_TRACKER_DRAIN_EN
      5: return 64'(issue_stall);
      6: return 64'(drain_ack);
`endif
      default: return 64'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input string name, input int sel, input logic [63:0] value);
    exp_t e;
    e.name  = name;
    e.sel   = sel;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic push_state(input string name, input int q, input logic ovf, input logic unf, input logic rng);
    push_exp({name, "_query"}, 0, 64'(q));
    push_exp({name, "_busy"}, 1, 64'(busy_exp));
    push_exp({name, "_ovf"}, 2, 64'(ovf));
    push_exp({name, "_unf"}, 3, 64'(unf));
    push_exp({name, "_rng"}, 4, 64'(rng));
  endtask

  // One clock of stimulus; inputs change on the falling edge and return to idle afterwards.
  task automatic apply_stimulus(input logic iv, input int iw, input logic rv, input int rw,
                                input logic fv, input int fw);
    issue_valid  = iv;
    issue_wfid   = WFID_W'(iw);
    retire_valid = rv;
    retire_wfid  = WFID_W'(rw);
    flush_valid  = fv;
    flush_wfid   = WFID_W'(fw);
    @(posedge clk);
    @(negedge clk);
    issue_valid  = 1'b0;
    retire_valid = 1'b0;
    flush_valid  = 1'b0;
  endtask

  task automatic check_output();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.value) else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.name, obs, e.value);
      end
    end
  endtask

  initial begin
    $display("[TB] start");
    @(negedge clk);
    push_state("reset", 0, 1'b0, 1'b0, 1'b0);
`ifdef WF_TRACKER_DRAIN_EN
    push_exp("reset_stall", 5, 64'd0);
    push_exp("reset_ack", 6, 64'd0);
`endif
    check_output();
    rst = 1'b1;

    // Three back-to-back issues to wavefront 5.
    query_wfid = 6'd5;
    for (int k = 0; k < 3; k++) begin
      busy_exp[5] = 1'b1;
      push_exp("ramp5_query", 0, 64'(k));
      push_exp("ramp5_busy", 1, 64'(busy_exp));
      apply_stimulus(1'b1, 5, 1'b0, 0, 1'b0, 0);
      check_output();
    end
    push_state("ramp5_final", 3, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();

    // Simultaneous issue and retire on wavefront 7 at count 2.
    query_wfid = 6'd7;
    apply_stimulus(1'b1, 7, 1'b0, 0, 1'b0, 0);
    apply_stimulus(1'b1, 7, 1'b0, 0, 1'b0, 0);
    busy_exp[7] = 1'b1;
    apply_stimulus(1'b1, 7, 1'b1, 7, 1'b0, 0);
    push_state("netzero7", 2, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();

    // Flush dominates a same-cycle retire and a same-cycle issue on wavefront 12.
    query_wfid = 6'd12;
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 12, 1'b0, 0, 1'b0, 0);
    busy_exp[12] = 1'b1;
    push_exp("pre_flush12_query", 0, 64'd3);
    push_exp("pre_flush12_busy", 1, 64'(busy_exp));
    check_output();
    busy_exp[12] = 1'b0;
    push_exp("flush_retire12_busy", 1, 64'(busy_exp));
    push_exp("flush_retire12_unf", 3, 64'd0);
    apply_stimulus(1'b0, 0, 1'b1, 12, 1'b1, 12);
    check_output();
    push_exp("flush_issue12_busy", 1, 64'(busy_exp));
    apply_stimulus(1'b1, 12, 1'b0, 0, 1'b1, 12);
    check_output();
    push_state("after_flush12", 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();

    // Out-of-range issue touches no counter.
    query_wfid = 6'd5;
    push_state("range45", 3, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b1, 45, 1'b0, 0, 1'b0, 0);
    check_output();
    query_wfid = 6'd45;
    push_state("query_oob", 0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();

    // Retire at zero count is sticky.
    query_wfid = 6'd0;
    push_state("underflow0", 0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 0, 1'b1, 0, 1'b0, 0);
    check_output();
    push_state("underflow_sticky", 0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();

    // Saturation on wavefront 39.
    query_wfid = 6'd39;
    for (int k = 1; k <= 16; k++) begin
      busy_exp[39] = 1'b1;
      push_exp("sat39_query", 0, 64'(k - 1));
      push_exp("sat39_ovf", 2, 64'(k == 16));
      push_exp("sat39_busy", 1, 64'(busy_exp));
      apply_stimulus(1'b1, 39, 1'b0, 0, 1'b0, 0);
      check_output();
    end
    push_exp("sat39_retire_query", 0, 64'd15);
    apply_stimulus(1'b0, 0, 1'b1, 39, 1'b0, 0);
    check_output();
    push_state("sat39_after_retire", 14, 1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();

    // Asynchronous reset in the middle of a cycle.
    issue_valid = 1'b1;
    issue_wfid  = 6'd39;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    busy_exp = '0;
    push_state("midreset", 0, 1'b0, 1'b0, 1'b0);
    check_output();
    @(negedge clk);
    issue_valid = 1'b0;
    rst = 1'b1;
    push_state("midreset_cleared", 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();

`ifdef WF_TRACKER_DRAIN_EN
    // Drain handshake with wavefront 3 holding two instructions.
    query_wfid = 6'd3;
    apply_stimulus(1'b1, 3, 1'b0, 0, 1'b0, 0);
    apply_stimulus(1'b1, 3, 1'b0, 0, 1'b0, 0);
    busy_exp[3] = 1'b1;
    drain_req = 1'b1;
    push_exp("drain_req_stall", 5, 64'd1);
    push_exp("drain_req_ack", 6, 64'd0);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();
    push_exp("drain_ret1_busy", 1, 64'(busy_exp));
    push_exp("drain_ret1_stall", 5, 64'd1);
    push_exp("drain_ret1_ack", 6, 64'd0);
    apply_stimulus(1'b0, 0, 1'b1, 3, 1'b0, 0);
    check_output();
    busy_exp = '0;
    push_exp("drain_ret2_busy", 1, 64'(busy_exp));
    push_exp("drain_ret2_ack", 6, 64'd0);
    apply_stimulus(1'b0, 0, 1'b1, 3, 1'b0, 0);
    check_output();
    for (int k = 0; k < 2; k++) begin
      push_exp("drain_done_ack", 6, 64'd1);
      push_exp("drain_done_stall", 5, 64'd1);
      apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
      check_output();
    end
    drain_req = 1'b0;
    push_exp("drain_release_ack", 6, 64'd0);
    push_exp("drain_release_stall", 5, 64'd0);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();

    // Issuing while stalled is counted and flagged.
    drain_req = 1'b1;
    push_exp("stall_again", 5, 64'd1);
    push_exp("stall_again_ovf", 2, 64'd0);
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
    check_output();
    busy_exp[3] = 1'b1;
    push_exp("stall_viol_ovf", 2, 64'd1);
    push_exp("stall_viol_busy", 1, 64'(busy_exp));
    apply_stimulus(1'b1, 3, 1'b0, 0, 1'b0, 0);
    check_output();
    drain_req = 1'b0;
    apply_stimulus(1'b0, 0, 1'b0, 0, 1'b0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
